// File: rtl/bram_line_player.sv
// Line-wide single-port BRAM buffer: host loads lines, then plays them back in a loop, one line per next strobe.
// Optional macro BRAM_READBACK_EN: host read of mem[addr] while idle with en=1, we=0.
//
// state | meaning
// IDLE  | host access; write_rdy follows ~generator_mode one cycle late
// CLEAR | zero sweep over all addresses, one per cycle
// PRIME | read of address 0 in flight
// RUN   | line_out = mem[generator_addr], advance on next
module bram_line_player #(
    parameter int DATA_WIDTH = 256,
    parameter int BRAM_DEPTH = 16,
    localparam int AW = $clog2(BRAM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] line_in,
    input  logic                  we,
    input  logic                  en,
    input  logic                  generator_mode,
    input  logic                  clr_bram,
    input  logic                  next,
    output logic [DATA_WIDTH-1:0] line_out,
    output logic                  valid_line_out,
    output logic [AW-1:0]         generator_addr,
    output logic                  write_rdy
);

    typedef enum logic [1:0] {IDLE, CLEAR, PRIME, RUN} state_t;

    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(BRAM_DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(BRAM_DEPTH - 1);
    localparam logic [AW-1:0] ONE_A     = AW'(1);
    localparam logic [AW:0]   ONE_L     = (AW+1)'(1);

    state_t                state_q, state_d;
    logic [AW:0]           len_q, len_d;
    logic [AW-1:0]         clr_cnt_q, clr_cnt_d;
    logic [AW-1:0]         gen_addr_q, gen_addr_d;
    logic                  valid_q, valid_d;
    logic                  write_rdy_q, write_rdy_d;
    logic [DATA_WIDTH-1:0] line_q;
    logic [DATA_WIDTH-1:0] mem [BRAM_DEPTH];

    logic          addr_ok;
    logic          wr_accept;
    logic          rb_req;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          clr_we;
    logic [AW-1:0] gen_addr_nxt;

    assign addr_ok   = {1'b0, addr} < DEPTH_W;
    // write_rdy_q can only be high while in IDLE, so it alone qualifies the host port
    assign wr_accept = write_rdy_q & we & en & addr_ok & ~clr_bram;

`ifdef BRAM_READBACK_EN
    assign rb_req = (state_q == IDLE) & en & ~we & addr_ok & ~clr_bram & ~generator_mode;
`else
    assign rb_req = 1'b0;
`endif

    assign gen_addr_nxt = ({1'b0, gen_addr_q} == len_q - ONE_L) ? '0 : gen_addr_q + ONE_A;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            clr_cnt_q   <= '0;
            gen_addr_q  <= '0;
            valid_q     <= 1'b0;
            write_rdy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            clr_cnt_q   <= clr_cnt_d;
            gen_addr_q  <= gen_addr_d;
            valid_q     <= valid_d;
            write_rdy_q <= write_rdy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (clr_bram) begin
            state_d   = CLEAR;
            clr_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE:  if (generator_mode && len_q != '0) state_d = PRIME;
                CLEAR: begin
                    clr_cnt_d = clr_cnt_q + ONE_A;
                    if (clr_cnt_q == LAST_ADDR) state_d = IDLE;
                end
                PRIME: state_d = generator_mode ? RUN : IDLE;
                RUN:   if (!generator_mode) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        rd_en       = 1'b0;
        rd_addr     = gen_addr_q;
        clr_we      = 1'b0;
        valid_d     = 1'b0;
        write_rdy_d = 1'b0;
        gen_addr_d  = gen_addr_q;
        len_d       = len_q;
        if (clr_bram) begin
            gen_addr_d = '0;
            len_d      = '0;
        end else begin
            if (wr_accept && {1'b0, addr} >= len_q) len_d = {1'b0, addr} + ONE_L;
            case (state_q)
                IDLE: begin
                    write_rdy_d = ~generator_mode;
                    if (rb_req) begin
                        rd_en   = 1'b1;
                        rd_addr = addr;
                        valid_d = 1'b1;
                    end
                end
                CLEAR: clr_we = 1'b1;
                PRIME: begin
                    gen_addr_d = '0;
                    if (generator_mode) begin
                        rd_en   = 1'b1;
                        rd_addr = '0;
                        valid_d = 1'b1;
                    end
                end
                RUN: begin
                    if (generator_mode) begin
                        rd_en   = 1'b1;
                        valid_d = 1'b1;
                        if (next) begin
                            rd_addr    = gen_addr_nxt;
                            gen_addr_d = gen_addr_nxt;
                        end
                    end else begin
                        gen_addr_d = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory carries no reset; rst only stops an in-progress clear sweep or write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we)
                mem[clr_cnt_q] <= '0;
            else if (wr_accept)
                mem[addr] <= line_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            line_q <= '0;
        else if (rd_en)
            line_q <= mem[rd_addr];
    end

    assign line_out       = line_q;
    assign valid_line_out = valid_q;
    assign generator_addr = gen_addr_q;
    assign write_rdy      = write_rdy_q;

endmodule

// File: doc/bram_line_player.md
# bram_line_player

Line-wide single-port BRAM buffer with a looping playback generator. The host writes up to `BRAM_DEPTH` lines through a simple address/data/enable port. It then switches to generator mode, and the block streams the stored lines in address order, wrapping forever, advancing one line per `next` strobe. The block sits between the PS-side waveform loader and the DAC-side sample consumer, and is the device end of the write/playback interface used by the existing BRAM testbench.

## Interface
- `DATA_WIDTH`, 256, line width in bits (multiple of 32).
- `BRAM_DEPTH`, 16, number of lines (≥2). `AW = $clog2(BRAM_DEPTH)`.

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `addr` in AW: host write address (read address with readback).
- `line_in` in DATA_WIDTH: host write data.
- `we` in 1: write enable, qualified by `en`.
- `en` in 1: port enable.
- `generator_mode` in 1: level; 1 = play back, 0 = host access.
- `clr_bram` in 1: single-cycle pulse that zeroes the memory and the stored depth.
- `next` in 1: consumer advance strobe.
- `line_out` out DATA_WIDTH: current playback line.
- `valid_line_out` out 1: `line_out` and `generator_addr` are valid.
- `generator_addr` out AW: address of the line on `line_out`.
- `write_rdy` out 1: host writes accepted this cycle.

## Operation
- **States:** IDLE, CLEAR, PRIME, RUN.
- **Stored depth `len`:** width AW+1, set to max(accepted write addr)+1. Cleared to 0 by `rst` and `clr_bram`.
- **IDLE:**
  - `write_rdy=1` iff `generator_mode=0`.
  - A write is accepted when `write_rdy & we & en & addr<BRAM_DEPTH`. Writes with `addr≥BRAM_DEPTH` are dropped and do not change `len`.
  - If `generator_mode=1` and `len>0`, go to PRIME.
- **CLEAR:**
  - Writes zero to addresses 0..BRAM_DEPTH-1, one per cycle, then goes to IDLE.
  - `write_rdy=0` and `valid_line_out=0` throughout.
  - A `clr_bram` pulse seen in any state enters CLEAR with the counter at 0; a pulse during CLEAR restarts the sweep.
  - `clr_bram` wins over a simultaneous write, and the write is dropped.
- **PRIME:** issues a read of address 0, then goes to RUN.
- **RUN:**
  - `line_out=mem[generator_addr]`, `valid_line_out=1`.
  - On a cycle with `next=1`, `generator_addr` advances at the next edge, wrapping from `len-1` to 0. `line_out` updates at that same edge.
  - `next=0` holds both outputs.
- **Leaving generator mode:** `generator_mode=0` in PRIME or RUN sends the block to IDLE. The next edge sets `valid_line_out=0` and `generator_addr=0`, and `line_out` holds its value. Re-entry always restarts at address 0.
- **Read path:** the BRAM read is registered with 1-cycle latency. The read address is `generator_addr+1` (wrapped) when advancing, otherwise `generator_addr`. This sustains one line per cycle with `next` held high.
- **Reset values:** `line_out=0`, `valid_line_out=0`, `generator_addr=0`, `write_rdy=0`, state IDLE, `len=0`. Memory contents are not cleared by `rst`.
- **Reset mid-operation:** abandons CLEAR or RUN immediately and applies the reset values.

## Timing
- `write_rdy` rises on the first edge after `rst` falls.
- A write accepted at edge N is readable by any playback read issued after edge N.
- `generator_mode` rises before edge E0 with `len>0`:
  - PRIME after E0.
  - At E1, `valid_line_out=1`, `line_out=mem[0]`, `generator_addr=0`.
- `next` sampled high at edge E: the outputs after E show the following line.
- Throughput: one line per cycle.
- CLEAR occupies BRAM_DEPTH cycles. `write_rdy` returns high on edge BRAM_DEPTH+1 after the pulse.
- Write-port latency to `len`: 1 cycle.

## Configuration
- **`BRAM_READBACK_EN` defined:** in IDLE, `en=1 & we=0` reads `mem[addr]`. The edge after the read shows `line_out` with the data and a one-cycle `valid_line_out` pulse; `generator_addr` is unchanged.
- **Undefined:** `en & ~we` is ignored, and `valid_line_out` is asserted only in RUN.

## Test plan
- **Reset:** hold `rst` 3 cycles → all outputs at reset values; `write_rdy=1` on the first edge after release.
- **Write and play, next held high:** write 16 random lines to addr 0..15, set `generator_mode=1`, hold `next=1` → `valid_line_out` two edges later. Lines then appear as `mem[0..15]` with `generator_addr` 0..15, repeating 0..15 for 3 full passes with no gaps.
- **Partial depth, random `next`:** write 5 lines, toggle `next` at random 1–20-cycle intervals → `generator_addr` wraps 4→0. Outputs hold while `next=0`, with no skipped or repeated lines.
- **Clear:** pulse `clr_bram` during RUN → `valid_line_out` low next edge and `write_rdy=0` for 16 cycles. Afterwards `len=0`, so `generator_mode=1` keeps `valid_line_out=0`. A new write to addr 0 followed by play yields line 0 only, and other addresses read back 0 with readback enabled.
- **Generator restart:** toggle `generator_mode` 1/0 randomly (1–5-cycle phases) after writing 8 lines, then hold it at 1 → playback restarts at addr 0 with `mem[0]`.
- **Collisions:** `clr_bram` together with `we=en=1` at addr 3 → write dropped and addr 3 reads 0. `rst` mid-CLEAR → IDLE next edge, and `write_rdy` rises on the first edge after `rst` falls.
